mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external memory port between instruction-side (fetch/I-cache fill) and data-side (D-cache fill/writeback) requesters.
- Sits between the cache line-fill logic and the Avalon-MM style memory interconnect.
- Owns arbitration, burst sequencing, waitrequest gating and read-data steering.
- One transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data beat width.
- BURST_WIDTH, 4, burstcount width; legal burst length 1..2**(BURST_WIDTH-1).

Ports:
- clock  in  1  clock
- reset_n  in  1  async active-low reset
- ic_addr  in  ADDR_WIDTH  I-side read address
- ic_rd  in  1  I-side read request
- ic_burstcount  in  BURST_WIDTH  I-side burst length
- ic_waitrequest  out  1  I-side command stall
- ic_rddata  out  DATA_WIDTH  I-side read beat
- ic_rddatavalid  out  1  I-side beat valid
- dc_addr  in  ADDR_WIDTH  D-side address
- dc_rd  in  1  D-side read request
- dc_wr  in  1  D-side write request
- dc_wrdata  in  DATA_WIDTH  D-side write beat
- dc_burstcount  in  BURST_WIDTH  D-side burst length
- dc_waitrequest  out  1  D-side command/beat stall
- dc_rddata  out  DATA_WIDTH  D-side read beat
- dc_rddatavalid  out  1  D-side beat valid
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rd  out  1  memory read
- mem_wr  out  1  memory write
- mem_wrdata  out  DATA_WIDTH  memory write beat
- mem_burstcount  out  BURST_WIDTH  memory burst length
- mem_waitrequest  in  1  memory stall
- mem_rddata  in  DATA_WIDTH  memory read beat
- mem_rddatavalid  in  1  memory beat valid

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clock. State=IDLE, last_grant=D, beat counter=0. mem_rd=mem_wr=0; ic/dc_waitrequest=1; ic/dc_rddatavalid=0. Reset mid-burst abandons the transaction with no recovery handshake.
- States: IDLE, CMD_I, CMD_D, RDATA, WDATA.
- IDLE: clients see waitrequest=1.
  - ic_rd alone -> CMD_I.
  - dc_rd^dc_wr alone -> CMD_D.
  - Both requesting -> grant the side != last_grant (first tie after reset goes to I); update last_grant on grant.
  - Decision is registered, so minimum request-to-memory latency is 1 cycle.
- CMD_x: mux granted client addr/burstcount/rd/wr/wrdata to mem_*. Granted client waitrequest = mem_waitrequest; the other stays 1.
  - Burstcount 0 is forwarded as 1.
  - Read accepted (mem_rd & ~mem_waitrequest): latch len, counter=0 -> RDATA.
  - Write first beat accepted: counter=1. If len==1 -> IDLE, else -> WDATA.
  - Granted client drops rd/wr before acceptance: cancel -> IDLE, no beats counted.
  - dc_rd & dc_wr together is illegal; the read wins.
- RDATA: mem_rd=0; route mem_rddata/mem_rddatavalid to the granted side only, other side's rddatavalid=0. Each valid beat increments the counter. On the beat where counter+1==len -> IDLE.
- WDATA: mem_wr=dc_wr, mem_wrdata=dc_wrdata; addr/burstcount held from the CMD beat. dc_waitrequest=mem_waitrequest. Each accepted beat increments the counter; the last beat (counter+1==len) -> IDLE. A dc_wr gap inserts idle beats (mem_wr=0) and is not counted.
- mem_rddatavalid outside RDATA is dropped. rddata outputs may carry mem_rddata unconditionally; only valid is gated.
- Counter width: BURST_WIDTH; wrap impossible for legal lengths.
- Back-to-back: IDLE is always visited between transactions, giving one dead cycle that makes round-robin fairness observable.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, CMD_I, CMD_D, RDATA, WDATA};
  - grant enum {GNT_I, GNT_D}.
- Sub-module: none required; the two-way round-robin picker stays inline.

Test Plan:
- Single I read: ic_rd, addr 0x100, burst 4, mem_waitrequest low 2 cycles after CMD -> mem_rd with 0x100/4; ic receives exactly 4 rddatavalid; dc_rddatavalid never 1; back to IDLE.
- Tie after reset: ic_rd and dc_rd in same cycle -> I granted first, D granted next; repeated tie alternates I,D,I,D.
- D write burst 4 to 0x200 with mem_waitrequest toggling and a one-cycle dc_wr gap -> exactly 4 mem_wr beats accepted, data in order, addr/burstcount stable throughout.
- D single write, burst 1 -> one accepted beat, return to IDLE next cycle; ic request pending meanwhile granted right after.
- Cancel: dc_rd dropped while mem_waitrequest=1 in CMD_D -> no mem transaction completes, IDLE, pending ic_rd granted.
- Async reset asserted mid-RDATA after 2 of 8 beats -> outputs reset values immediately; stray mem_rddatavalid after reset not forwarded.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package mem_arb_pkg;

   // Arbiter sequencing: pick a side, issue its command, then stream its beats.
   typedef enum logic [2:0] {
      IDLE,
      CMD_I,
      CMD_D,
      RDATA,
      WDATA
   } state_t;

   // Which requester currently owns (or last owned) the memory port.
   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter sharing one Avalon-MM style memory port between
// the instruction-side fill logic and the data-side fill/writeback logic.
// Only one transaction is in flight; IDLE is visited between transactions.
//
// Handshake: a command or write beat transfers on a cycle where the master
// holds rd/wr high and the slave's waitrequest is low. Read beats transfer on
// every cycle where rddatavalid is high; there is no back-pressure on them.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   // instruction side
   input  logic [ADDR_WIDTH-1:0]  ic_addr,
   input  logic                   ic_rd,
   input  logic [BURST_WIDTH-1:0] ic_burstcount,
   output logic                   ic_waitrequest,
   output logic [DATA_WIDTH-1:0]  ic_rddata,
   output logic                   ic_rddatavalid,
   // data side
   input  logic [ADDR_WIDTH-1:0]  dc_addr,
   input  logic                   dc_rd,
   input  logic                   dc_wr,
   input  logic [DATA_WIDTH-1:0]  dc_wrdata,
   input  logic [BURST_WIDTH-1:0] dc_burstcount,
   output logic                   dc_waitrequest,
   output logic [DATA_WIDTH-1:0]  dc_rddata,
   output logic                   dc_rddatavalid,
   // memory side
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_rd,
   output logic                   mem_wr,
   output logic [DATA_WIDTH-1:0]  mem_wrdata,
   output logic [BURST_WIDTH-1:0] mem_burstcount,
   input  logic                   mem_waitrequest,
   input  logic [DATA_WIDTH-1:0]  mem_rddata,
   input  logic                   mem_rddatavalid
);

   // A burstcount of zero is treated as a single beat.
   function automatic logic [BURST_WIDTH-1:0] fix_burst(input logic [BURST_WIDTH-1:0] bc);
      return (bc == '0) ? BURST_WIDTH'(1) : bc;
   endfunction

   state_t                 state_q, state_d;
   grant_t                 gnt_q, gnt_d;
   grant_t                 last_grant_q, last_grant_d;
   logic [BURST_WIDTH-1:0] len_q, len_d;
   logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
   logic [BURST_WIDTH-1:0] bc_q, bc_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

   logic                   d_req;
   logic                   d_is_rd;
   logic                   d_is_wr;
   logic [BURST_WIDTH-1:0] cnt_inc;
   logic [BURST_WIDTH-1:0] ic_len;
   logic [BURST_WIDTH-1:0] dc_len;

   // Read data is steered to both sides unconditionally; only valid is gated.
   assign ic_rddata = mem_rddata;
   assign dc_rddata = mem_rddata;

   // Simultaneous dc_rd and dc_wr is illegal; the read takes precedence.
   assign d_req   = dc_rd | dc_wr;
   assign d_is_rd = dc_rd;
   assign d_is_wr = dc_wr & ~dc_rd;
   assign cnt_inc = cnt_q + BURST_WIDTH'(1);
   assign ic_len  = fix_burst(ic_burstcount);
   assign dc_len  = fix_burst(dc_burstcount);

   // State and transaction registers; reset abandons any transaction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         gnt_q        <= GNT_D;
         last_grant_q <= GNT_D;
         len_q        <= '0;
         cnt_q        <= '0;
         bc_q         <= '0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         bc_q         <= bc_d;
         addr_q       <= addr_d;
      end
   end

   // Next-state, grant and port-mux logic.
   always_comb begin
      state_d        = state_q;
      gnt_d          = gnt_q;
      last_grant_d   = last_grant_q;
      len_d          = len_q;
      cnt_d          = cnt_q;
      bc_d           = bc_q;
      addr_d         = addr_q;
      mem_addr       = addr_q;
      mem_burstcount = bc_q;
      mem_rd         = 1'b0;
      mem_wr         = 1'b0;
      mem_wrdata     = dc_wrdata;
      ic_waitrequest = 1'b1;
      dc_waitrequest = 1'b1;
      ic_rddatavalid = 1'b0;
      dc_rddatavalid = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // On a tie, the side that did not win last time is served.
            if (ic_rd && (!d_req || last_grant_q == GNT_D)) begin
               state_d      = CMD_I;
               gnt_d        = GNT_I;
               last_grant_d = GNT_I;
            end else if (d_req) begin
               state_d      = CMD_D;
               gnt_d        = GNT_D;
               last_grant_d = GNT_D;
            end
         end

         CMD_I: begin
            mem_addr       = ic_addr;
            mem_burstcount = ic_len;
            mem_rd         = ic_rd;
            ic_waitrequest = mem_waitrequest;
            addr_d         = ic_addr;
            bc_d           = ic_len;
            if (!ic_rd) begin
               state_d = IDLE;
            end else if (!mem_waitrequest) begin
               len_d   = ic_len;
               cnt_d   = '0;
               state_d = RDATA;
            end
         end

         CMD_D: begin
            mem_addr       = dc_addr;
            mem_burstcount = dc_len;
            mem_rd         = d_is_rd;
            mem_wr         = d_is_wr;
            dc_waitrequest = mem_waitrequest;
            addr_d         = dc_addr;
            bc_d           = dc_len;
            if (!d_req) begin
               state_d = IDLE;
            end else if (!mem_waitrequest) begin
               len_d = dc_len;
               if (d_is_rd) begin
                  cnt_d   = '0;
                  state_d = RDATA;
               end else begin
                  cnt_d   = BURST_WIDTH'(1);
                  state_d = (dc_len == BURST_WIDTH'(1)) ? IDLE : WDATA;
               end
            end
         end

         RDATA: begin
            if (gnt_q == GNT_I) begin
               ic_rddatavalid = mem_rddatavalid;
            end else begin
               dc_rddatavalid = mem_rddatavalid;
            end
            if (mem_rddatavalid) begin
               if (cnt_inc == len_q) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         WDATA: begin
            mem_wr         = dc_wr;
            dc_waitrequest = mem_waitrequest;
            if (dc_wr && !mem_waitrequest) begin
               if (cnt_inc == len_q) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] ic_addr;
  logic          ic_rd;
  logic [BW-1:0] ic_burstcount;
  logic          ic_waitrequest;
  logic [DW-1:0] ic_rddata;
  logic          ic_rddatavalid;
  logic [AW-1:0] dc_addr;
  logic          dc_rd;
  logic          dc_wr;
  logic [DW-1:0] dc_wrdata;
  logic [BW-1:0] dc_burstcount;
  logic          dc_waitrequest;
  logic [DW-1:0] dc_rddata;
  logic          dc_rddatavalid;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wrdata;
  logic [BW-1:0] mem_burstcount;
  logic          mem_waitrequest;
  logic [DW-1:0] mem_rddata;
  logic          mem_rddatavalid;

  int n_total;
  int n_bad;
  logic [DW-1:0] exp_q[$];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ic_addr         (ic_addr),
    .ic_rd           (ic_rd),
    .ic_burstcount   (ic_burstcount),
    .ic_waitrequest  (ic_waitrequest),
    .ic_rddata       (ic_rddata),
    .ic_rddatavalid  (ic_rddatavalid),
    .dc_addr         (dc_addr),
    .dc_rd           (dc_rd),
    .dc_wr           (dc_wr),
    .dc_wrdata       (dc_wrdata),
    .dc_burstcount   (dc_burstcount),
    .dc_waitrequest  (dc_waitrequest),
    .dc_rddata       (dc_rddata),
    .dc_rddatavalid  (dc_rddatavalid),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_wrdata      (mem_wrdata),
    .mem_burstcount  (mem_burstcount),
    .mem_waitrequest (mem_waitrequest),
    .mem_rddata      (mem_rddata),
    .mem_rddatavalid (mem_rddatavalid)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ic_addr = '0; ic_rd = 1'b0; ic_burstcount = '0;
    dc_addr = '0; dc_rd = 1'b0; dc_wr = 1'b0; dc_wrdata = '0; dc_burstcount = '0;
    mem_waitrequest = 1'b1; mem_rddata = '0; mem_rddatavalid = 1'b0;
  endtask

  // Called one cycle after the grant (arbiter in CMD for this side).
  // Holds the command for nwait cycles, accepts it, streams the beats.
  task automatic serve_read(input bit side_d, input logic [31:0] addr,
                            input logic [3:0] bc, input int nwait);
    logic [3:0]  len;
    logic [31:0] d;
    len = (bc == 4'd0) ? 4'd1 : bc;
    mem_waitrequest = 1'b1;
    #1;
    chk("rd_cmd_rd", mem_rd, 1);
    chk("rd_cmd_wr", mem_wr, 0);
    chk("rd_cmd_addr", mem_addr, addr);
    chk("rd_cmd_bc", mem_burstcount, len);
    chk("rd_other_wait", side_d ? ic_waitrequest : dc_waitrequest, 1);
    for (int i = 0; i < nwait; i++) begin
      chk("rd_gnt_wait_hi", side_d ? dc_waitrequest : ic_waitrequest, 1);
      cyc();
      chk("rd_cmd_hold", mem_rd, 1);
    end
    mem_waitrequest = 1'b0;
    #1;
    chk("rd_gnt_wait_lo", side_d ? dc_waitrequest : ic_waitrequest, 0);
    cyc();
    if (side_d) dc_rd = 1'b0; else ic_rd = 1'b0;
    mem_waitrequest = 1'b1;
    #1;
    chk("rd_data_mem_rd", mem_rd, 0);
    for (int b = 0; b < int'(len); b++) begin
      if (b == 1) begin
        mem_rddatavalid = 1'b0;
        #1;
        chk("rd_gap_valid", side_d ? dc_rddatavalid : ic_rddatavalid, 0);
        cyc();
      end
      d = $urandom;
      exp_q.push_back(d);
      mem_rddata = d;
      mem_rddatavalid = 1'b1;
      #1;
      chk("rd_beat_valid", side_d ? dc_rddatavalid : ic_rddatavalid, 1);
      chk("rd_other_valid", side_d ? ic_rddatavalid : dc_rddatavalid, 0);
      chk("rd_beat_data", side_d ? dc_rddata : ic_rddata, exp_q.pop_front());
      cyc();
    end
    // burst complete: a stray beat must not reach either side
    #1;
    chk("rd_end_stray", side_d ? dc_rddatavalid : ic_rddatavalid, 0);
    chk("rd_end_wait", side_d ? dc_waitrequest : ic_waitrequest, 1);
    mem_rddatavalid = 1'b0;
  endtask

  // stimulus and scoreboard
  initial begin
    logic [3:0] wait_pat [8];
    int acc;
    n_total = 0;
    n_bad = 0;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_ic_wait", ic_waitrequest, 1);
    chk("rst_dc_wait", dc_waitrequest, 1);
    chk("rst_ic_valid", ic_rddatavalid, 0);
    chk("rst_dc_valid", dc_rddatavalid, 0);
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // tie after reset: I first, then alternating D, I, D
    ic_rd = 1'b1; ic_addr = 32'h40; ic_burstcount = 4'd1;
    dc_rd = 1'b1; dc_addr = 32'h80; dc_burstcount = 4'd0;
    #1;
    chk("tie_idle_ic_wait", ic_waitrequest, 1);
    chk("tie_idle_mem_rd", mem_rd, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k % 2 == 0) serve_read(1'b0, 32'h40, 4'd1, 1);
      else            serve_read(1'b1, 32'h80, 4'd0, 0);
      if (k % 2 == 0) ic_rd = 1'b1; else dc_rd = 1'b1;
    end
    ic_rd = 1'b0; dc_rd = 1'b0;
    cyc();

    // single I read, burst 4, command stalled 2 cycles
    ic_rd = 1'b1; ic_addr = 32'h100; ic_burstcount = 4'd4;
    #1;
    chk("ird_latency", mem_rd, 0);
    cyc();
    serve_read(1'b0, 32'h100, 4'd4, 2);
    cyc();

    // D write burst 4 with waitrequest toggling and a dc_wr gap
    wait_pat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hCAFE_0000 + 32'(i));
    dc_addr = 32'h200; dc_burstcount = 4'd4; dc_wr = 1'b1; dc_wrdata = exp_q[0];
    mem_waitrequest = 1'b1;
    cyc();
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      mem_waitrequest = (c < 8) ? wait_pat[c][0] : 1'b0;
      dc_wr = (c == 2) ? 1'b0 : 1'b1;
      dc_wrdata = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
      #1;
      chk("wr_addr", mem_addr, 32'h200);
      chk("wr_bc", mem_burstcount, 4);
      chk("wr_mem_wr", mem_wr, dc_wr);
      chk("wr_dc_wait", dc_waitrequest, mem_waitrequest);
      if (mem_wr && !mem_waitrequest && exp_q.size() > 0) begin
        chk("wr_data", mem_wrdata, exp_q.pop_front());
        acc++;
      end
      cyc();
    end
    dc_wr = 1'b0;
    mem_waitrequest = 1'b1;
    #1;
    chk("wr_beats", acc, 4);
    chk("wr_end_mem_wr", mem_wr, 0);
    chk("wr_end_dc_wait", dc_waitrequest, 1);

    // D single write with an I read arriving meanwhile
    dc_wr = 1'b1; dc_addr = 32'h300; dc_burstcount = 4'd1; dc_wrdata = 32'h1234_5678;
    mem_waitrequest = 1'b0;
    #1;
    chk("sw_idle_dc_wait", dc_waitrequest, 1);
    cyc();
    ic_rd = 1'b1; ic_addr = 32'h500; ic_burstcount = 4'd2;
    #1;
    chk("sw_mem_wr", mem_wr, 1);
    chk("sw_mem_rd", mem_rd, 0);
    chk("sw_data", mem_wrdata, 32'h1234_5678);
    chk("sw_bc", mem_burstcount, 1);
    chk("sw_dc_wait", dc_waitrequest, 0);
    chk("sw_ic_wait", ic_waitrequest, 1);
    cyc();
    dc_wr = 1'b0;
    #1;
    chk("sw_idle_mem_wr", mem_wr, 0);
    chk("sw_idle_ic_wait", ic_waitrequest, 1);
    cyc();
    serve_read(1'b0, 32'h500, 4'd2, 0);
    cyc();

    // cancel: dc_rd dropped while stalled, pending I read granted next
    dc_rd = 1'b1; dc_addr = 32'h600; dc_burstcount = 4'd2;
    mem_waitrequest = 1'b1;
    cyc();
    ic_rd = 1'b1; ic_addr = 32'h700; ic_burstcount = 4'd1;
    #1;
    chk("cx_mem_rd", mem_rd, 1);
    chk("cx_addr", mem_addr, 32'h600);
    chk("cx_dc_wait", dc_waitrequest, 1);
    cyc();
    dc_rd = 1'b0;
    #1;
    chk("cx_drop_mem_rd", mem_rd, 0);
    cyc();
    mem_rddatavalid = 1'b1;
    #1;
    chk("cx_idle_mem_rd", mem_rd, 0);
    chk("cx_stray_dc", dc_rddatavalid, 0);
    chk("cx_stray_ic", ic_rddatavalid, 0);
    mem_rddatavalid = 1'b0;
    cyc();
    serve_read(1'b0, 32'h700, 4'd1, 1);
    cyc();

    // async reset mid-RDATA after 2 of 8 beats
    dc_rd = 1'b1; dc_addr = 32'h800; dc_burstcount = 4'd8;
    mem_waitrequest = 1'b0;
    cyc();
    #1;
    chk("ar_dc_wait", dc_waitrequest, 0);
    cyc();
    dc_rd = 1'b0;
    mem_waitrequest = 1'b1;
    for (int b = 0; b < 2; b++) begin
      mem_rddata = 32'hBEEF_0000 + 32'(b);
      mem_rddatavalid = 1'b1;
      #1;
      chk("ar_beat_valid", dc_rddatavalid, 1);
      cyc();
    end
    #1;
    chk("ar_pre_valid", dc_rddatavalid, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_dc_valid", dc_rddatavalid, 0);
    chk("ar_ic_valid", ic_rddatavalid, 0);
    chk("ar_dc_wait_hi", dc_waitrequest, 1);
    chk("ar_ic_wait_hi", ic_waitrequest, 1);
    chk("ar_mem_rd", mem_rd, 0);
    chk("ar_mem_wr", mem_wr, 0);
    #2;
    reset_n = 1'b1;
    cyc();
    chk("ar_post_dc_valid", dc_rddatavalid, 0);
    chk("ar_post_ic_valid", ic_rddatavalid, 0);
    mem_rddatavalid = 1'b0;
    cyc();

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
